// File: rtl/hold_timer_sched_pkg.sv
// Shared types and reset values for the one-second hold timer scheduler.
package hold_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARB   = 2'd1,
      ST_COUNT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam state_e STATE_RST = ST_IDLE;
   localparam logic   BIT_RST   = 1'b0;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hold_timer_sched_if.sv
// Request/clear inputs and grant/done/status outputs of the hold timer scheduler.
interface hold_timer_sched_if #(
   parameter int N_REQ      = 4,
   parameter int CNT_ONESEC = 1_000_000
);
   localparam int CNT_W = $clog2(CNT_ONESEC + 1);

   logic [N_REQ-1:0] i_req;
   logic [N_REQ-1:0] i_clr;
   logic [N_REQ-1:0] o_gnt;
   logic [N_REQ-1:0] o_done;
   logic             o_busy;
   logic [CNT_W-1:0] o_cnt;

   modport master (
      output i_req, i_clr,
      input  o_gnt, o_done, o_busy, o_cnt
   );

   modport slave (
      input  i_req, i_clr,
      output o_gnt, o_done, o_busy, o_cnt
   );
endinterface

// File: rtl/hold_timer_sched_rr_pick.sv
// Combinational round-robin picker: first eligible channel at or after the pointer.
module rr_pick
   import hold_timer_pkg::*;
#(
   parameter int N_REQ = 4,
   localparam int IDX_W = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] i_elig,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   // Scan N_REQ positions starting at the pointer, wrapping modulo N_REQ.
   always_comb begin
      int j;
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      j       = 0;
      for (int i = 0; i < N_REQ; i++) begin
         j = (int'(i_ptr) + i) % N_REQ;
         if (!o_valid && i_elig[j]) begin
            o_valid  = 1'b1;
            o_gnt[j] = 1'b1;
            o_idx    = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/hold_timer_sched.sv
// One shared hold counter timed against the round-robin selected request.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | nothing granted; wait for an eligible request
//   ST_ARB   | pick next eligible channel from the rr pointer
//   ST_COUNT | granted channel held high; count toward CNT_ONESEC
//   ST_DONE  | done flag just latched; release grant, advance pointer
module hold_timer_sched
   import hold_timer_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int CNT_ONESEC = 1_000_000
) (
   input logic              i_clk,
   input logic              i_rst,
   hold_timer_sched_if.slave bus
);

   localparam int CNT_W = $clog2(CNT_ONESEC + 1);
   localparam int IDX_W = idx_w(N_REQ);

   state_e           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] done_set;
   logic [N_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;

   // Channel after g, wrapping for any N_REQ (stays 0 when N_REQ is 1).
   function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
      if (int'(g) >= N_REQ - 1) return '0;
      return g + IDX_W'(1);
   endfunction

   assign elig = bus.i_req & ~done_q;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .i_elig  (elig),
      .i_ptr   (ptr_q),
      .o_gnt   (pick_gnt),
      .o_idx   (pick_idx),
      .o_valid (pick_valid)
   );

   // Next-state, grant, counter and pointer decisions.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      done_set = '0;
      case (state_q)
         ST_IDLE: begin
            gnt_d = '0;
            cnt_d = '0;
            if (|elig) state_d = ST_ARB;
         end
         ST_ARB: begin
            cnt_d = '0;
            if (pick_valid) begin
               gnt_d   = pick_gnt;
               idx_d   = pick_idx;
               state_d = ST_COUNT;
            end else begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_COUNT: begin
            if (!bus.i_req[idx_q]) begin
               gnt_d   = '0;
               cnt_d   = '0;
               ptr_d   = ptr_after(idx_q);
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_W'(CNT_ONESEC - 1)) begin
               done_set[idx_q] = 1'b1;
               cnt_d           = '0;
               state_d         = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            gnt_d   = '0;
            cnt_d   = '0;
            ptr_d   = ptr_after(idx_q);
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      // A set on the same edge as a clear wins.
      done_d = (done_q & ~bus.i_clr) | done_set;
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= STATE_RST;
         gnt_q   <= '0;
         done_q  <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.o_gnt  = gnt_q;
   assign bus.o_done = done_q;
   assign bus.o_busy = (state_q != ST_IDLE) ? 1'b1 : BIT_RST;
   assign bus.o_cnt  = cnt_q;

endmodule
